// File: rtl/hub75_stream_writer.sv
// hub75_stream_writer: turns a raster-ordered {R,G,B} pixel stream with
// sof/eol markers into framebuffer writes for hub75_driver. It tracks the
// column and row, flags malformed lines and frames, and resynchronises on
// the next start-of-frame.
//
// Handshake: a beat is accepted when i_valid & o_ready. o_ready is i_enable
// delayed by one cycle; there is no other back-pressure, and the upstream
// must hold a beat until it is accepted.
module hub75_stream_writer #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8,
  localparam int frame_size_p = hpixel_p * vpixel_p,
  localparam int addr_width_p = (frame_size_p > 1) ? $clog2(frame_size_p) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_enable,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [3*bpp_p-1:0]      i_data,
  input  logic                    i_sof,
  input  logic                    i_eol,
  output logic [addr_width_p-1:0] o_framebuf_wr_addr,
  output logic [3*bpp_p-1:0]      o_framebuf_wr_data,
  output logic                    o_framebuf_wr_en,
  output logic                    o_frame_done,
  output logic                    o_err,
  output logic [15:0]             o_frame_count,
  output logic [1:0]              o_state
);

  localparam int x_w_lp = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int y_w_lp = (vpixel_p > 1) ? $clog2(vpixel_p) : 1;
  localparam logic [x_w_lp-1:0]       x_last_lp = x_w_lp'(hpixel_p - 1);
  localparam logic [y_w_lp-1:0]       y_last_lp = y_w_lp'(vpixel_p - 1);
  localparam logic [addr_width_p-1:0] row_step_lp = addr_width_p'(hpixel_p);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    ERR_SKIP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [x_w_lp-1:0]       x_q, x_d;
  logic [y_w_lp-1:0]       y_q, y_d;
  logic [addr_width_p-1:0] base_q, base_d;
  logic                    ready_q;
  logic                    wr_en_q, wr_en_d;
  logic [addr_width_p-1:0] wr_addr_q, wr_addr_d;
  logic [3*bpp_p-1:0]      wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [15:0]             count_q, count_d;

  // Beat classification. A sof beat is always placed at column 0 of row 0,
  // so the position used for this beat is forced to the origin on sof.
  logic                    accept;
  logic                    take;
  logic                    restart;
  logic [x_w_lp-1:0]       x_eff;
  logic [y_w_lp-1:0]       y_eff;
  logic [addr_width_p-1:0] base_eff;
  logic                    at_last_col;
  logic                    at_last_row;
  logic                    line_ok;
  logic                    bad_line;
  logic                    frame_end;

  assign accept      = i_valid & ready_q;
  assign take        = accept & (i_sof | (state_q == ACTIVE));
  assign restart     = accept & i_sof & (state_q == ACTIVE);
  assign x_eff       = i_sof ? '0 : x_q;
  assign y_eff       = i_sof ? '0 : y_q;
  assign base_eff    = i_sof ? '0 : base_q;
  assign at_last_col = (x_eff == x_last_lp);
  assign at_last_row = (y_eff == y_last_lp);
  assign line_ok     = i_eol & at_last_col;
  // eol without last column (early) or last column without eol (missing)
  assign bad_line    = i_eol ^ at_last_col;
  assign frame_end   = take & line_ok & at_last_row;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_SOF;
    else     state_q <= state_d;
  end

  // Next-state: every written beat lands in ACTIVE unless it ends the frame
  // or breaks the line structure.
  always_comb begin
    state_d = state_q;
    if (take) begin
      if (bad_line)       state_d = ERR_SKIP;
      else if (frame_end) state_d = WAIT_SOF;
      else                state_d = ACTIVE;
    end
  end

  // Output and position next values for the written beat
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    base_d    = base_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    count_d   = count_q;
    if (take) begin
      wr_en_d   = 1'b1;
      wr_addr_d = base_eff + addr_width_p'(x_eff);
      wr_data_d = i_data;
      err_d     = restart | bad_line;
      if (line_ok) begin
        x_d = '0;
        if (at_last_row) begin
          y_d    = '0;
          base_d = '0;
          done_d = ~restart;
          if (!restart) count_d = count_q + 16'd1;
        end else begin
          y_d    = y_eff + y_w_lp'(1);
          base_d = base_eff + row_step_lp;
        end
      end else if (bad_line) begin
        x_d    = x_eff;
        y_d    = y_eff;
        base_d = base_eff;
      end else begin
        x_d    = x_eff + x_w_lp'(1);
        y_d    = y_eff;
        base_d = base_eff;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      base_q    <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      base_q    <= base_d;
      ready_q   <= i_enable;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign o_ready            = ready_q;
  assign o_framebuf_wr_en   = wr_en_q;
  assign o_framebuf_wr_addr = wr_addr_q;
  assign o_framebuf_wr_data = wr_data_q;
  assign o_frame_done       = done_q;
  assign o_err              = err_q;
  assign o_frame_count      = count_q;
  assign o_state            = state_q;

endmodule

// File: tb/tb_hub75_stream_writer.sv
// Bench for hub75_stream_writer: directed scenario sequence with randomized
// data and gaps, checked cycle by cycle against a position/arithmetic model.
module tb_hub75_stream_writer;

  localparam int HP = 64;
  localparam int VP = 64;
  localparam int BPP = 8;
  localparam int DW = 3 * BPP;
  localparam int AW = 12;
  localparam int W = AW + DW + 2;

  // clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_enable, i_valid, i_sof, i_eol;
  logic [DW-1:0] i_data;
  logic          o_ready, o_framebuf_wr_en, o_frame_done, o_err;
  logic [AW-1:0] o_framebuf_wr_addr;
  logic [DW-1:0] o_framebuf_wr_data;
  logic [15:0]   o_frame_count;
  logic [1:0]    o_state;

  hub75_stream_writer #(.hpixel_p(HP), .vpixel_p(VP), .bpp_p(BPP)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .i_sof(i_sof), .i_eol(i_eol),
    .o_framebuf_wr_addr(o_framebuf_wr_addr),
    .o_framebuf_wr_data(o_framebuf_wr_data),
    .o_framebuf_wr_en(o_framebuf_wr_en), .o_frame_done(o_frame_done),
    .o_err(o_err), .o_frame_count(o_frame_count), .o_state(o_state)
  );

  // scoreboard: {addr, data, err, done} of each expected write
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: mode 0 waiting for sof, 1 in frame, 2 skipping
  int   m_mode, m_x, m_y, m_count;
  logic m_ready;
  logic last_acc;
  int   cyc = 0;
  int   drop_start = -100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic wr, e_err, e_done;
    int a;
    last_acc = i_valid && m_ready;
    m_ready  = i_enable;
    if (!last_acc) return;
    wr = 1'b0; e_err = 1'b0; e_done = 1'b0;
    if (i_sof) begin
      e_err = (m_mode == 1);
      m_x = 0; m_y = 0; wr = 1'b1;
    end else if (m_mode == 1) begin
      wr = 1'b1;
    end
    if (!wr) return;
    a = m_y * HP + m_x;
    if (i_eol && m_x == HP - 1) begin
      m_x = 0; m_y++; m_mode = 1;
      if (m_y == VP) begin
        m_y = 0; m_mode = 0;
        if (!e_err) begin
          e_done = 1'b1;
          m_count = (m_count + 1) % 65536;
        end
      end
    end else if (i_eol || m_x == HP - 1) begin
      e_err = 1'b1; m_mode = 2;
    end else begin
      m_x++; m_mode = 1;
    end
    exp_q.push_back({a[AW-1:0], i_data, e_err, e_done});
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    chk("ready", 32'(o_ready), 32'(m_ready));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_en", 32'(o_framebuf_wr_en), 32'd1);
      chk("wr_addr", 32'(o_framebuf_wr_addr), 32'(e[W-1 -: AW]));
      chk("wr_data", 32'(o_framebuf_wr_data), 32'(e[DW+1:2]));
      chk("err", 32'(o_err), 32'(e[1]));
      chk("frame_done", 32'(o_frame_done), 32'(e[0]));
    end else begin
      chk("wr_en_idle", 32'(o_framebuf_wr_en), 32'd0);
      chk("err_idle", 32'(o_err), 32'd0);
      chk("done_idle", 32'(o_frame_done), 32'd0);
    end
    chk("frame_count", 32'(o_frame_count), 32'(m_count));
    chk("state", 32'(o_state), 32'(m_mode));
  endtask

  // one clock: enable follows the drop window, model at the edge, check after
  task automatic cycle();
    i_enable = !(cyc >= drop_start && cyc < drop_start + 5);
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  // driver: optional idle gap, then hold the beat until accepted
  task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input int gap_max);
    int n;
    n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (n) begin
      i_valid = 1'b0; i_sof = 1'($urandom_range(0, 1));
      i_eol = 1'($urandom_range(0, 1)); i_data = DW'($urandom);
      cycle();
    end
    i_valid = 1'b1; i_data = d; i_sof = s; i_eol = e;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    checks++;
    assert (last_acc) else begin
      errors++;
      $error("FAIL accept_timeout: observed waited %0d cycles expected acceptance", n);
    end
    i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
  endtask

  task automatic send_line(input int y, input int ncols, input int eol_col,
                           input logic sof_first, input logic addr_data, input int gap);
    for (int x = 0; x < ncols; x++)
      send(addr_data ? DW'(y * HP + x) : DW'($urandom), sof_first && x == 0, x == eol_col, gap);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
    repeat (n) cycle();
  endtask

  // reset with a valid sof beat presented; neither edge may produce a write
  task automatic do_reset();
    rst = 1'b1; i_enable = 1'b1; i_valid = 1'b1; i_sof = 1'b1; i_eol = 1'b0;
    i_data = DW'($urandom);
    @(posedge clk);
    m_mode = 0; m_x = 0; m_y = 0; m_count = 0; m_ready = 1'b0;
    exp_q.delete();
    cyc++;
    @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_wr_en", 32'(o_framebuf_wr_en), 32'd0);
    chk("rst_addr", 32'(o_framebuf_wr_addr), 32'd0);
    chk("rst_data", 32'(o_framebuf_wr_data), 32'd0);
    chk("rst_done", 32'(o_frame_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_count", 32'(o_frame_count), 32'd0);
    chk("rst_state", 32'(o_state), 32'd0);
    rst = 1'b0;
    cycle();
    idle(1);
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
    i_data = '0;
    m_mode = 0; m_x = 0; m_y = 0; m_count = 0; m_ready = 1'b0; last_acc = 1'b0;
    do_reset();

    // beats before any sof are dropped
    for (int k = 0; k < 6; k++) send(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1);

    // full frame, data = address
    for (int y = 0; y < VP; y++) send_line(y, HP, HP - 1, y == 0, 1'b1, 0);
    idle(2);
    chk("count_after_full", 32'(o_frame_count), 32'd1);

    // missing eol: 70 beats on row 0
    send_line(0, 70, -1, 1'b1, 1'b0, 0);
    idle(2);
    chk("state_missing_eol", 32'(o_state), 32'd2);

    // early eol at x=10 of row 3, rest of row dropped, then resync
    for (int y = 0; y < 3; y++) send_line(y, HP, HP - 1, y == 0, 1'b0, 1);
    send_line(3, HP, 10, 1'b0, 1'b0, 1);
    idle(2);
    chk("state_early_eol", 32'(o_state), 32'd2);
    for (int y = 0; y < 20; y++) send_line(y, HP, HP - 1, y == 0, 1'b0, 1);

    // mid-frame sof at row 20, x=5
    send_line(20, 5, -1, 1'b0, 1'b0, 0);
    send_line(0, HP, HP - 1, 1'b1, 1'b0, 0);
    chk("count_after_restart", 32'(o_frame_count), 32'd1);
    for (int y = 1; y < 4; y++) send_line(y, HP, HP - 1, 1'b0, 1'b0, 1);

    // enable dropped for 5 cycles mid-line, valid held high
    drop_start = cyc + 20;
    send_line(4, HP, HP - 1, 1'b0, 1'b0, 0);
    drop_start = -100;

    // reset mid-frame at row 30, then a fresh frame
    for (int y = 5; y < 30; y++) send_line(y, HP, HP - 1, 1'b0, 1'b0, 0);
    send_line(30, 10, -1, 1'b0, 1'b0, 0);
    do_reset();
    for (int y = 0; y < VP; y++) send_line(y, HP, HP - 1, y == 0, 1'b0, 2);
    idle(3);
    chk("count_after_reset_frame", 32'(o_frame_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed time limit reached expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hub75_stream_writer.md
Name: hub75_stream_writer

Overview:
Upstream feeder for hub75_driver. Accepts a raster-ordered pixel stream with start-of-frame and end-of-line markers over a valid/ready handshake, and tracks column and row. Drives the framebuffer write port (address, {R,G,B} data, write enable) that hub75_driver consumes. Detects malformed frames, resynchronises on the next start-of-frame, and reports frame completion and error status.

Parameters:
hpixel_p, 64, display width in pixels (columns per line)
vpixel_p, 64, display height in pixels (lines per frame)
bpp_p, 8, bits per colour channel
frame_size_p (localparam), hpixel_p*vpixel_p, pixels per frame
addr_width_p (localparam), $clog2(frame_size_p), framebuffer address width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
i_enable  in  1  stream acceptance enable
i_valid  in  1  input beat valid
o_ready  out  1  writer ready to accept a beat
i_data  in  3*bpp_p  pixel packed {R,G,B}
i_sof  in  1  beat is first pixel of a frame (x=0, y=0)
i_eol  in  1  beat is last pixel of a line
o_framebuf_wr_addr  out  addr_width_p  write address, y*hpixel_p + x
o_framebuf_wr_data  out  3*bpp_p  write data {R,G,B}
o_framebuf_wr_en  out  1  write strobe, one cycle per pixel
o_frame_done  out  1  one-cycle pulse when a well-formed frame completes
o_err  out  1  one-cycle pulse on a framing error
o_frame_count  out  16  count of completed well-formed frames, wraps 0xFFFF->0
o_state  out  2  current FSM state, for debug

Behaviour:
- Reset (rst=1 at a clk edge): state=WAIT_SOF, x=0, y=0, o_ready=0, o_framebuf_wr_en=0, wr_addr=0, wr_data=0, o_frame_done=0, o_err=0, o_frame_count=0. Reset mid-frame discards the partial frame; no write is issued on the reset cycle or the cycle after.
- o_ready is registered from i_enable: o_ready(n+1)=i_enable(n). A beat is accepted when i_valid & o_ready. No back-pressure exists beyond i_enable.
- Write latency: an accepted beat that is written produces wr_en=1 with matching addr/data on the next cycle. wr_en is 0 in every other cycle. Address = y*hpixel_p + x, computed without a multiplier: a row base register is incremented by hpixel_p at each line end.
- State encoding for o_state: WAIT_SOF=0, ACTIVE=1, ERR_SKIP=2.
- WAIT_SOF:
  - Beats without sof are discarded (no write, no error).
  - A sof beat is written at addr 0. Then x=1, y=0, state=ACTIVE.
- ACTIVE, accepted beat:
  - sof=1: frame restart. o_err pulses, the beat is written at addr 0, then x=1, y=0.
  - else the beat is written at (x,y), then:
    - eol=1 and x==hpixel_p-1: x=0, y=y+1. If y was vpixel_p-1: o_frame_done pulses, o_frame_count increments, y=0, state=WAIT_SOF.
    - eol=1 and x<hpixel_p-1 (early eol): o_err pulses, state=ERR_SKIP.
    - eol=0 and x==hpixel_p-1 (missing eol): o_err pulses, state=ERR_SKIP.
    - otherwise: x=x+1.
- ERR_SKIP: beats without sof are discarded. A sof beat is handled exactly as in WAIT_SOF.
- sof and eol on the same beat: sof positions the beat at x=0. eol is then evaluated against column 0, which is legal only when hpixel_p==1; otherwise early-eol error applies.
- Status pulses (o_frame_done, o_err) are asserted in the same cycle as the corresponding wr_en. The two pulses are never asserted together.
- Addresses never exceed frame_size_p-1. No write is ever issued outside ACTIVE or the sof transition.

Test Plan:
- Full frame: after reset, i_enable=1, stream 64x64 beats (sof on the first, eol at every x=63), data = addr. Required: 4096 writes with addr 0..4095 and wr_data = addr; o_frame_done pulses once, aligned with the write to addr 4095; o_frame_count=1; o_err never asserted.
- Early eol: eol on x=10 of row 3. Required: write at addr 202, then o_err pulse. Remaining row-3 beats produce no writes. The next sof resumes writing at addr 0.
- Missing eol: row 0 runs 70 beats with no eol. Required: writes to addr 0..63, o_err on the addr-63 write, beats 64..69 dropped, state=ERR_SKIP.
- Mid-frame sof: sof arrives at row 20, x=5. Required: o_err pulse; that beat is written at addr 0; the following beats are written at addr 1, 2, ...; o_frame_count unchanged.
- Enable/handshake: drop i_enable for 5 cycles mid-line with i_valid held high. Required: o_ready falls one cycle later, no writes while ready=0, addresses continue without a gap. Pre-sof beats after reset produce no writes.
- Reset mid-frame: assert rst at row 30. Required: next-cycle outputs at reset values, o_frame_count=0; a new sof frame writes from addr 0.
